// File: rtl/uart_receiver_if.sv
// Signal bundle between the UART receiver (slave) and the logic that enables it
// and consumes received bytes (master).
interface uart_receiver_if;
   // Level semantics, no valid/ready: done or err stays high from the stop-bit sample
   // until the next accepted start bit, enabled=0 or reset; out is valid whenever done=1.
   logic       enabled;
   logic       in;
   logic       busy;
   logic       done;
   logic       err;
   logic [7:0] out;
   logic [2:0] state;

   modport master (
      output enabled,
      output in,
      input  busy,
      input  done,
      input  err,
      input  out,
      input  state
   );

   modport slave (
      input  enabled,
      input  in,
      output busy,
      output done,
      output err,
      output out,
      output state
   );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with a 2-flop input synchronizer and mid-bit sampling.
// Define RECEIVER_PARITY_EN to receive 8E1 frames (even parity checked before the stop bit).
module uart_receiver #(
   parameter int CLOCK_RATE = 100_000_000,
   parameter int BAUD_RATE  = 115_200
) (
   input  logic           clk,
   input  logic           rst_n,
   uart_receiver_if.slave bus
);

   localparam int CLKS_PER_BIT = CLOCK_RATE / BAUD_RATE;
   localparam int BAUD_W       = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 2;
   localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(CLKS_PER_BIT - 1);

   if (CLKS_PER_BIT < 4) begin : g_cfg_check
      $error("uart_receiver: CLOCK_RATE/BAUD_RATE must be at least 4");
   end

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [1:0]          sync_q, sync_d;
   logic [BAUD_W-1:0]   baud_q, baud_d;
   logic [2:0]          bit_idx_q, bit_idx_d;
   logic [7:0]          shift_q, shift_d;
   logic [7:0]          out_q, out_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic                rx;
   logic                baud_last;
   logic                frame_ok;

   assign rx        = sync_q[1];
   assign baud_last = (baud_q == BIT_LAST);

`ifdef RECEIVER_PARITY_EN
   logic par_q, par_d;

   // Even parity: the received parity bit must equal the XOR of the data bits.
   assign frame_ok = rx && (par_q == ^shift_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_q <= 1'b0;
      end else begin
         par_q <= par_d;
      end
   end
`else
   assign frame_ok = rx;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         sync_q    <= 2'b11;
         baud_q    <= '0;
         bit_idx_q <= 3'd0;
         shift_q   <= 8'h00;
         out_q     <= 8'h00;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         sync_q    <= sync_d;
         baud_q    <= baud_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         out_q     <= out_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   always_comb begin
      sync_d    = {sync_q[0], bus.in};
      state_d   = state_q;
      baud_d    = baud_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      out_d     = out_q;
      done_d    = done_q;
      err_d     = err_q;
`ifdef RECEIVER_PARITY_EN
      par_d     = par_q;
`endif

      if (!bus.enabled) begin
         // Disabling aborts any frame and drops the flags; out keeps the last good byte.
         state_d   = S_IDLE;
         baud_d    = '0;
         bit_idx_d = 3'd0;
         done_d    = 1'b0;
         err_d     = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (!rx) begin
                  state_d   = S_START;
                  baud_d    = '0;
                  bit_idx_d = 3'd0;
                  done_d    = 1'b0;
                  err_d     = 1'b0;
               end
            end

            S_START: begin
               if (baud_q == HALF_LAST) begin
                  baud_d    = '0;
                  bit_idx_d = 3'd0;
                  // A line already back high at mid start bit was a glitch, not a frame.
                  state_d   = rx ? S_IDLE : S_DATA;
               end else begin
                  baud_d = baud_q + 1'b1;
               end
            end

            S_DATA: begin
               if (baud_last) begin
                  baud_d             = '0;
                  shift_d[bit_idx_q] = rx;
                  bit_idx_d          = bit_idx_q + 3'd1;
                  if (bit_idx_q == 3'd7) begin
`ifdef RECEIVER_PARITY_EN
                     state_d = S_PARITY;
`else
                     state_d = S_STOP;
`endif
                  end
               end else begin
                  baud_d = baud_q + 1'b1;
               end
            end

`ifdef RECEIVER_PARITY_EN
            S_PARITY: begin
               if (baud_last) begin
                  baud_d  = '0;
                  par_d   = rx;
                  state_d = S_STOP;
               end else begin
                  baud_d = baud_q + 1'b1;
               end
            end
`endif

            S_STOP: begin
               if (baud_last) begin
                  // Leave at mid stop bit so a back-to-back start edge is not missed.
                  baud_d  = '0;
                  state_d = S_IDLE;
                  if (frame_ok) begin
                     out_d  = shift_q;
                     done_d = 1'b1;
                  end else begin
                     err_d = 1'b1;
                  end
               end else begin
                  baud_d = baud_q + 1'b1;
               end
            end

            default: begin
               state_d = S_IDLE;
               baud_d  = '0;
            end
         endcase
      end
   end

   assign bus.busy  = (state_q != S_IDLE);
   assign bus.done  = done_q;
   assign bus.err   = err_q;
   assign bus.out   = out_q;
   assign bus.state = state_q;

   a_flags_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(done_q && err_q));
   a_idle_baud_clear: assert property (@(posedge clk) disable iff (!rst_n)
                                       (state_q == S_IDLE) |-> (baud_q == '0));

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed scenarios plus random frames checked
// against a frame-level model (expected byte queue and settled flag values).
`timescale 1ns/1ps
module tb_uart_receiver;

   localparam int CLOCK_RATE = 1_600_000;
   localparam int BAUD_RATE  = 100_000;
   localparam int CPB        = CLOCK_RATE / BAUD_RATE;
`ifdef RECEIVER_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   uart_receiver_if bus ();

   uart_receiver #(
      .CLOCK_RATE (CLOCK_RATE),
      .BAUD_RATE  (BAUD_RATE)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // ---------------- model / scoreboard state ----------------
   logic [7:0] exp_q[$];
   logic [7:0] exp_out  = 8'h00;
   logic       exp_done = 1'b0;
   logic       exp_err  = 1'b0;
   logic       check_en = 1'b0;
   logic       done_prev = 1'b0;
   int         busy_cnt = 0;
   int         done_cnt = 0;
   int         err_cnt  = 0;
   int         total = 0;
   int         bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.done && !done_prev) begin
            check("done_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("done_byte", 32'(bus.out), 32'(exp_q.pop_front()));
         end
         if (check_en)
            check("idle_outputs", 32'({bus.busy, bus.done, bus.err, bus.out}),
                  32'({1'b0, exp_done, exp_err, exp_out}));
         if (bus.done && bus.err) check("done_err_exclusive", 32'd1, 32'd0);
      end
      done_prev = bus.done;
      if (bus.busy) busy_cnt++;
      if (bus.done) done_cnt++;
      if (bus.err)  err_cnt++;
   end

   // ---------------- driver tasks ----------------
   task automatic drive_bit(input logic b);
      bus.in = b;
      repeat (CPB) @(negedge clk);
   endtask

   // Idle line; the first bit period lets any false start (after a low stop bit) settle.
   task automatic idle_gap(input int bits);
      bus.in = 1'b1;
      if (bits > 0) begin
         repeat (CPB) @(negedge clk);
         check_en = 1'b1;
         repeat ((bits - 1) * CPB) @(negedge clk);
         check_en = 1'b0;
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
      logic active, good;
      int   d0, e0;
      active = bus.enabled;
      good   = stop_b && (!PAR_EN || (par_b == ^d));
      if (active && good) exp_q.push_back(d);
      check_en = 1'b0;
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) begin
         drive_bit(d[i]);
         if (i == 3) check("busy_mid", 32'(bus.busy), 32'(active));
      end
      if (PAR_EN) drive_bit(par_b);
      d0 = done_cnt;
      e0 = err_cnt;
      drive_bit(stop_b);
      check("stop_done", 32'(done_cnt != d0), 32'(active && good));
      check("stop_err", 32'(err_cnt != e0), 32'(active && !good));
      // A low stop bit is still low when the receiver is back in IDLE, so it is taken as
      // a new start, which clears err before being rejected as a false start.
      if (!active || !stop_b) begin
         exp_done = 1'b0;
         exp_err  = 1'b0;
      end else if (good) begin
         exp_out  = d;
         exp_done = 1'b1;
         exp_err  = 1'b0;
      end else begin
         exp_done = 1'b0;
         exp_err  = 1'b1;
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [7:0] d;
      logic       stop_b, par_b;
      int         gap, b0;

      bus.enabled = 1'b0;
      bus.in      = 1'b1;
      rst_n       = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_outputs", 32'({bus.busy, bus.done, bus.err, bus.out}), 32'd0);
      rst_n = 1'b1;
      bus.enabled = 1'b1;
      idle_gap(3);

      // Directed 0x5A, good frame
      send_frame(8'h5A, 1'b1, ^8'h5A);
      idle_gap(3);
      check("lit_5a_out", 32'(bus.out), 32'h5A);
      check("lit_5a_done", 32'(bus.done), 32'd1);

      // 0x3C with a low stop bit: out keeps 0x5A
      send_frame(8'h3C, 1'b0, ^8'h3C);
      idle_gap(3);
      check("lit_3c_out", 32'(bus.out), 32'h5A);

      // Disabled receiver ignores a whole frame
      bus.enabled = 1'b0;
      idle_gap(2);
      send_frame(8'hFF, 1'b1, ^8'hFF);
      idle_gap(3);
      bus.enabled = 1'b1;
      idle_gap(2);

      // Quarter-bit low glitch while idle: START only, back to IDLE
      b0 = busy_cnt;
      bus.in = 1'b0;
      repeat (CPB / 4) @(negedge clk);
      bus.in = 1'b1;
      repeat (CPB) @(negedge clk);
      check("glitch_busy_pulse", 32'(busy_cnt != b0), 32'd1);
      idle_gap(3);

      // Good 0x11, then drop enabled in the middle of 0x81
      send_frame(8'h11, 1'b1, ^8'h11);
      idle_gap(2);
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(1'((8'h81 >> i) & 8'h01));
      bus.enabled = 1'b0;
      repeat (2) @(negedge clk);
      check("abort_outputs", 32'({bus.busy, bus.done, bus.err, bus.out}), 32'({3'b000, 8'h11}));
      for (int i = 4; i < 8; i++) drive_bit(1'((8'h81 >> i) & 8'h01));
      if (PAR_EN) drive_bit(^8'h81);
      drive_bit(1'b1);
      exp_done = 1'b0;
      exp_err  = 1'b0;
      idle_gap(2);
      bus.enabled = 1'b1;
      idle_gap(2);

      // Back-to-back frames, no idle gap
      send_frame(8'hA5, 1'b1, ^8'hA5);
      check("lit_a5_out", 32'(bus.out), 32'hA5);
      send_frame(8'h01, 1'b1, ^8'h01);
      idle_gap(3);
      check("lit_01_out", 32'(bus.out), 32'h01);

`ifdef RECEIVER_PARITY_EN
      // 0x07 has odd weight, so a parity bit of 0 is wrong
      send_frame(8'h07, 1'b1, 1'b0);
      idle_gap(3);
      check("lit_par_err", 32'({bus.err, bus.done, bus.out}), 32'({2'b10, 8'h01}));
`endif

      // Random frames
      for (int n = 0; n < 24; n++) begin
         d      = 8'($urandom_range(0, 255));
         stop_b = ($urandom_range(0, 4) != 0);
         par_b  = (^d) ^ (PAR_EN && ($urandom_range(0, 4) == 0));
         send_frame(d, stop_b, par_b);
         gap = $urandom_range(0, 3);
         if (gap != 0) gap = gap + 1;
         if (!stop_b && gap < 2) gap = 2;
         idle_gap(gap);
      end
      idle_gap(3);

      // Reset in the middle of a frame
      check_en = 1'b0;
      drive_bit(1'b0);
      for (int i = 0; i < 3; i++) drive_bit(1'($urandom_range(0, 1)));
      rst_n = 1'b0;
      #1;
      check("midframe_reset", 32'({bus.busy, bus.done, bus.err, bus.out}), 32'd0);
      exp_q.delete();
      exp_out  = 8'h00;
      exp_done = 1'b0;
      exp_err  = 1'b0;
      for (int i = 3; i < 8; i++) drive_bit(1'b1);
      drive_bit(1'b1);
      rst_n = 1'b1;
      idle_gap(3);

      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Asynchronous serial (UART) receive block: 8N1 frames, LSB first, idle-high line.
- Oversamples the serial input with the system clock, delivers each received byte on a parallel output and flags completion or framing error.
- Sits between the external RX pin and the byte-consuming logic. Bit timing is derived from the same CLOCK_RATE/BAUD_RATE values used by the transmitter.

Parameters:
- CLOCK_RATE, 100_000_000, system clock frequency in Hz.
- BAUD_RATE, 115_200, serial bit rate in bit/s.
- CLKS_PER_BIT (localparam) = CLOCK_RATE / BAUD_RATE, integer division, truncated. Must be >= 4; compile-time error otherwise.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enabled  input  1  receiver enable; 0 = ignore line and abort any frame.
- in  input  1  serial RX line, asynchronous to clk, idle high.
- busy  output  1  high while a frame is in progress.
- done  output  1  high after a frame with a valid stop bit; level, held.
- err  output  1  high after a frame with an invalid stop bit; level, held.
- out  output  8  last correctly received byte.

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE, busy=0, done=0, err=0, out=8'h00, bit counter and baud counter = 0, synchronizer flops = 1.
- in passes through a 2-flop synchronizer. All decisions use the synchronized value. This adds 2 clk of latency.
- One baud counter counts 0..CLKS_PER_BIT-1. A 3-bit index counts data bits 0..7.
- IDLE:
  - busy=0.
  - If enabled=1 and synchronized in=0, go to START, clear the baud counter, clear done and err.
- START:
  - busy=1.
  - Wait CLKS_PER_BIT/2 clk (mid start bit), then sample.
  - Sample 0: go to DATA with bit index 0 and baud counter cleared.
  - Sample 1: false start; return to IDLE with no flag set.
- DATA:
  - busy=1.
  - Every CLKS_PER_BIT clk (mid-bit), sample into shift register position bit index, LSB first.
  - After bit 7, go to STOP.
- STOP:
  - busy=1.
  - After CLKS_PER_BIT clk, sample the line.
  - Sample 1: out <= shift register and done <= 1 in the same cycle.
  - Sample 0: err <= 1 and out unchanged.
  - Either case: go to IDLE next cycle with busy=0.
- Returning to IDLE at mid stop bit lets a back-to-back start bit be caught.
- done and err stay asserted until the next accepted start bit (falling edge in IDLE), enabled=0, or reset. done and err are never both 1.
- out holds its value until the next valid frame. It is also held when enabled=0 and across errored frames.
- enabled=0 in any state (synchronous): next cycle go to IDLE, busy=0, done=0, err=0, partial data discarded, out held.
- Line held low while IDLE after an error or break: a new frame starts. A stop-bit-0 break therefore produces repeated err frames. This is acceptable.
- Latency: done rises about 9.5 bit periods + 3 clk after the start-bit falling edge at the pin. It is guaranteed high by 10 bit periods.
- Bit-time error: truncation of CLKS_PER_BIT must stay within mid-bit tolerance. The block performs no fractional compensation.

Optional Feature:
- Macro: RECEIVER_PARITY_EN.
- Defined: frame is 8E1. A PARITY state is inserted after DATA and samples one extra bit at mid-bit. After the stop sample:
  - err=1 if the parity bit does not equal the XOR of the 8 data bits, or if the stop bit is 0.
  - done=1 only if both parity and stop are good.
  - out is updated only on done.
- Undefined: no parity state; 8N1 exactly as above.

Test Plan:
- Reset, enabled=1, send 0x5A (start 0, bits 0,1,0,1,1,0,1,0, stop 1) -> busy=1 during frame; at 10 bit periods done=1, err=0, out=8'h5A, busy=0.
- Send 0x3C with stop bit 0 -> err=1, done=0, out keeps previous 8'h5A.
- Low glitch of 0.25 bit period while idle -> busy pulses through START only, returns IDLE, done/err/out unchanged.
- enabled=0, send 0xFF frame -> busy stays 0, out unchanged. Drop enabled mid-frame of 0x81 -> busy=0 next cycles, done=0, out unchanged.
- Back-to-back 0xA5 then 0x01 with no idle gap -> done after each, out=8'hA5 then 8'h01, no err.
- Assert rst_n=0 mid-frame -> outputs immediately reset values (out=00, busy=0). With RECEIVER_PARITY_EN, 0x07 with parity 0 -> err=1, out unchanged.
